// File: rtl/segre_ex_stage_if.sv
// Shared opcode/memop types and the ID/EX -> EX/MEM bundle interface for the Segre execute stage.
// The slave side is the execute stage; the master side is whoever drives the ID/EX bundle.
package segre_pkg;
    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI,
        ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
        ALU_JAL, ALU_JALR
    } alu_opcode_e;

    typedef enum logic [1:0] {
        MEMOP_BYTE, MEMOP_HALF, MEMOP_WORD
    } memop_data_type_e;
endpackage

interface segre_ex_stage_if #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 32,
    parameter int REG_SIZE  = 5
);
    logic                        valid_ex_i;
    segre_pkg::alu_opcode_e      alu_opcode_i;
    logic [WORD_SIZE-1:0]        alu_src_a_i;
    logic [WORD_SIZE-1:0]        alu_src_b_i;
    logic [WORD_SIZE-1:0]        br_src_a_i;
    logic [WORD_SIZE-1:0]        br_src_b_i;
    logic                        rf_we_i;
    logic [REG_SIZE-1:0]         rf_waddr_i;
    segre_pkg::memop_data_type_e memop_type_i;
    logic                        memop_sign_ext_i;
    logic                        memop_rd_i;
    logic                        memop_wr_i;
    logic [WORD_SIZE-1:0]        memop_rf_data_i;
    logic                        is_jaljalr_i;
    logic [ADDR_SIZE-1:0]        seq_new_pc_i;
    logic                        block_ex_i;
    logic                        inject_nops_i;

    logic [WORD_SIZE-1:0]        alu_res_o;
    logic                        rf_we_o;
    logic [REG_SIZE-1:0]         rf_waddr_o;
    segre_pkg::memop_data_type_e memop_type_o;
    logic                        memop_sign_ext_o;
    logic                        memop_rd_o;
    logic                        memop_wr_o;
    logic [WORD_SIZE-1:0]        memop_rf_data_o;
    logic                        tkn_br_o;
    logic [ADDR_SIZE-1:0]        new_pc_o;
    logic                        valid_mem_o;

    modport slave (
        input  valid_ex_i, alu_opcode_i, alu_src_a_i, alu_src_b_i, br_src_a_i, br_src_b_i,
               rf_we_i, rf_waddr_i, memop_type_i, memop_sign_ext_i, memop_rd_i, memop_wr_i,
               memop_rf_data_i, is_jaljalr_i, seq_new_pc_i, block_ex_i, inject_nops_i,
        output alu_res_o, rf_we_o, rf_waddr_o, memop_type_o, memop_sign_ext_o, memop_rd_o,
               memop_wr_o, memop_rf_data_o, tkn_br_o, new_pc_o, valid_mem_o
    );

    modport master (
        output valid_ex_i, alu_opcode_i, alu_src_a_i, alu_src_b_i, br_src_a_i, br_src_b_i,
               rf_we_i, rf_waddr_i, memop_type_i, memop_sign_ext_i, memop_rd_i, memop_wr_i,
               memop_rf_data_i, is_jaljalr_i, seq_new_pc_i, block_ex_i, inject_nops_i,
        input  alu_res_o, rf_we_o, rf_waddr_o, memop_type_o, memop_sign_ext_o, memop_rd_o,
               memop_wr_o, memop_rf_data_o, tkn_br_o, new_pc_o, valid_mem_o
    );
endinterface

// File: rtl/segre_ex_stage.sv
// Segre execute stage: ALU, branch/jump resolution and the EX/MEM register, including the
// one-cycle redirect pulse and the self-squash of the instruction trailing a taken branch.
module segre_ex_stage
    import segre_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 32
) (
    input logic             clk_i,
    input logic             rsn_i,
    segre_ex_stage_if.slave ex
);
    logic signed [WORD_SIZE-1:0] a_s;
    logic signed [WORD_SIZE-1:0] b_s;
    logic signed [WORD_SIZE-1:0] bra_s;
    logic signed [WORD_SIZE-1:0] brb_s;
    logic [WORD_SIZE-1:0]        sum;
    logic [WORD_SIZE-1:0]        alu_out;
    logic [WORD_SIZE-1:0]        res;
    logic [ADDR_SIZE-1:0]        target;
    logic [4:0]                  shamt;
    logic                        taken;
    logic                        is_branch;
    logic                        squash_q;

    assign a_s   = ex.alu_src_a_i;
    assign b_s   = ex.alu_src_b_i;
    assign bra_s = ex.br_src_a_i;
    assign brb_s = ex.br_src_b_i;
    assign sum   = ex.alu_src_a_i + ex.alu_src_b_i;
    assign shamt = ex.alu_src_b_i[4:0];

    always_comb begin
        alu_out   = sum;
        taken     = 1'b0;
        is_branch = 1'b0;
        case (ex.alu_opcode_i)
            ALU_ADD:  alu_out = sum;
            ALU_SUB:  alu_out = ex.alu_src_a_i - ex.alu_src_b_i;
            ALU_AND:  alu_out = ex.alu_src_a_i & ex.alu_src_b_i;
            ALU_OR:   alu_out = ex.alu_src_a_i | ex.alu_src_b_i;
            ALU_XOR:  alu_out = ex.alu_src_a_i ^ ex.alu_src_b_i;
            ALU_SLL:  alu_out = ex.alu_src_a_i << shamt;
            ALU_SRL:  alu_out = ex.alu_src_a_i >> shamt;
            ALU_SRA:  alu_out = a_s >>> shamt;
            ALU_SLT:  alu_out = WORD_SIZE'(a_s < b_s);
            ALU_SLTU: alu_out = WORD_SIZE'(ex.alu_src_a_i < ex.alu_src_b_i);
            ALU_LUI:  alu_out = ex.alu_src_b_i;
            ALU_BEQ:  begin is_branch = 1'b1; taken = (ex.br_src_a_i == ex.br_src_b_i); end
            ALU_BNE:  begin is_branch = 1'b1; taken = (ex.br_src_a_i != ex.br_src_b_i); end
            ALU_BLT:  begin is_branch = 1'b1; taken = (bra_s < brb_s); end
            ALU_BGE:  begin is_branch = 1'b1; taken = (bra_s >= brb_s); end
            ALU_BLTU: begin is_branch = 1'b1; taken = (ex.br_src_a_i < ex.br_src_b_i); end
            ALU_BGEU: begin is_branch = 1'b1; taken = (ex.br_src_a_i >= ex.br_src_b_i); end
            ALU_JAL:  taken = 1'b1;
            ALU_JALR: taken = 1'b1;
            default:  alu_out = sum;
        endcase
    end

    // Jumps return the link value; JALR targets are forced halfword aligned
    assign res    = ex.is_jaljalr_i ? WORD_SIZE'(ex.seq_new_pc_i) : alu_out;
    assign target = (ex.alu_opcode_i == ALU_JALR) ? {sum[ADDR_SIZE-1:1], 1'b0}
                                                  : sum[ADDR_SIZE-1:0];

    // ---- EX/MEM register boundary ----
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            ex.alu_res_o        <= '0;
            ex.rf_we_o          <= 1'b0;
            ex.rf_waddr_o       <= '0;
            ex.memop_type_o     <= MEMOP_BYTE;
            ex.memop_sign_ext_o <= 1'b0;
            ex.memop_rd_o       <= 1'b0;
            ex.memop_wr_o       <= 1'b0;
            ex.memop_rf_data_o  <= '0;
            ex.tkn_br_o         <= 1'b0;
            ex.new_pc_o         <= '0;
            ex.valid_mem_o      <= 1'b0;
            squash_q            <= 1'b0;
        end else if (ex.block_ex_i) begin
            // Held contents stay, but the redirect must not repeat
            ex.tkn_br_o <= 1'b0;
        end else if (ex.inject_nops_i || squash_q || !ex.valid_ex_i) begin
            ex.valid_mem_o <= 1'b0;
            ex.rf_we_o     <= 1'b0;
            ex.memop_rd_o  <= 1'b0;
            ex.memop_wr_o  <= 1'b0;
            ex.tkn_br_o    <= 1'b0;
            squash_q       <= 1'b0;
        end else begin
            ex.alu_res_o        <= res;
            ex.rf_we_o          <= ex.rf_we_i & ~is_branch;
            ex.rf_waddr_o       <= ex.rf_waddr_i;
            ex.memop_type_o     <= ex.memop_type_i;
            ex.memop_sign_ext_o <= ex.memop_sign_ext_i;
            ex.memop_rd_o       <= ex.memop_rd_i;
            ex.memop_wr_o       <= ex.memop_wr_i;
            ex.memop_rf_data_o  <= ex.memop_rf_data_i;
            ex.tkn_br_o         <= taken;
            ex.new_pc_o         <= target;
            ex.valid_mem_o      <= 1'b1;
            squash_q            <= taken;
        end
    end
endmodule

// File: tb/tb_segre_ex_stage.sv
// Directed self-checking bench for segre_ex_stage: ALU ops, branch/jump redirect, squash,
// block/inject priority and asynchronous reset.
module tb_segre_ex_stage;
    import segre_pkg::*;

    logic clk_i = 1'b0;
    logic rsn_i = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_i = ~clk_i;

    segre_ex_stage_if bus ();

    segre_ex_stage dut (
        .clk_i (clk_i),
        .rsn_i (rsn_i),
        .ex    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input alu_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] bra, input logic [31:0] brb, input logic jal,
                         input logic [31:0] seq);
        bus.valid_ex_i       = 1'b1;
        bus.alu_opcode_i     = op;
        bus.alu_src_a_i      = a;
        bus.alu_src_b_i      = b;
        bus.br_src_a_i       = bra;
        bus.br_src_b_i       = brb;
        bus.rf_we_i          = 1'b1;
        bus.rf_waddr_i       = 5'd7;
        bus.memop_type_i     = MEMOP_BYTE;
        bus.memop_sign_ext_i = 1'b0;
        bus.memop_rd_i       = 1'b0;
        bus.memop_wr_i       = 1'b0;
        bus.memop_rf_data_i  = 32'h0;
        bus.is_jaljalr_i     = jal;
        bus.seq_new_pc_i     = seq;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".alu_res"}, bus.alu_res_o, 32'h0);
        check({tag, ".new_pc"}, bus.new_pc_o, 32'h0);
        check({tag, ".tkn_br"}, 32'(bus.tkn_br_o), 32'h0);
        check({tag, ".valid"}, 32'(bus.valid_mem_o), 32'h0);
        check({tag, ".rf_we"}, 32'(bus.rf_we_o), 32'h0);
        check({tag, ".memop_type"}, 32'(bus.memop_type_o), 32'h0);
    endtask

    initial begin
        drive(ALU_ADD, 0, 0, 0, 0, 0, 0);
        bus.valid_ex_i    = 1'b0;
        bus.block_ex_i    = 1'b0;
        bus.inject_nops_i = 1'b0;
        #3 rsn_i = 1'b0;
        #1;
        check_zero("reset");
        step();
        step();
        #2 rsn_i = 1'b1;

        // ALU operations
        drive(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0);
        step();
        check("add_wrap", bus.alu_res_o, 32'h0);
        check("add_valid", 32'(bus.valid_mem_o), 32'h1);
        check("add_we", 32'(bus.rf_we_o), 32'h1);
        check("add_tkn", 32'(bus.tkn_br_o), 32'h0);
        drive(ALU_SRA, 32'h8000_0000, 32'h4, 0, 0, 0, 0);
        step();
        check("sra", bus.alu_res_o, 32'hF800_0000);
        drive(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0);
        step();
        check("slt", bus.alu_res_o, 32'h1);
        drive(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0);
        step();
        check("sltu", bus.alu_res_o, 32'h0);

        // Taken BEQ, squashed ADD, then normal ADD
        drive(ALU_BEQ, 32'h100, 32'h20, 5, 5, 0, 0);
        step();
        check("beq_tkn", 32'(bus.tkn_br_o), 32'h1);
        check("beq_pc", bus.new_pc_o, 32'h120);
        check("beq_we", 32'(bus.rf_we_o), 32'h0);
        drive(ALU_ADD, 2, 3, 0, 0, 0, 0);
        step();
        check("sq_valid", 32'(bus.valid_mem_o), 32'h0);
        check("sq_we", 32'(bus.rf_we_o), 32'h0);
        check("sq_tkn", 32'(bus.tkn_br_o), 32'h0);
        drive(ALU_ADD, 7, 8, 0, 0, 0, 0);
        step();
        check("post_sq_res", bus.alu_res_o, 32'd15);
        check("post_sq_valid", 32'(bus.valid_mem_o), 32'h1);

        // JALR link value and aligned target
        drive(ALU_JALR, 32'h203, 32'h0, 0, 0, 1, 32'h44);
        step();
        check("jalr_pc", bus.new_pc_o, 32'h202);
        check("jalr_res", bus.alu_res_o, 32'h44);
        check("jalr_tkn", 32'(bus.tkn_br_o), 32'h1);
        check("jalr_we", 32'(bus.rf_we_o), 32'h1);

        // Squash consumes an invalid bundle; the next valid one runs
        bus.valid_ex_i = 1'b0;
        step();
        check("jalr_sq_valid", 32'(bus.valid_mem_o), 32'h0);
        drive(ALU_ADD, 3, 4, 0, 0, 0, 0);
        step();
        check("jalr_after_res", bus.alu_res_o, 32'd7);
        check("jalr_after_valid", 32'(bus.valid_mem_o), 32'h1);

        // Taken BNE then three blocked cycles
        drive(ALU_BNE, 32'h40, 32'h4, 1, 2, 0, 0);
        step();
        check("bne_tkn", 32'(bus.tkn_br_o), 32'h1);
        check("bne_pc", bus.new_pc_o, 32'h44);
        bus.block_ex_i = 1'b1;
        drive(ALU_ADD, 9, 9, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("blk_tkn", 32'(bus.tkn_br_o), 32'h0);
            check("blk_valid", 32'(bus.valid_mem_o), 32'h1);
            check("blk_pc", bus.new_pc_o, 32'h44);
            check("blk_res", bus.alu_res_o, 32'h44);
        end
        bus.block_ex_i = 1'b0;
        step();
        check("blk_sq_valid", 32'(bus.valid_mem_o), 32'h0);
        drive(ALU_ADD, 1, 1, 0, 0, 0, 0);
        step();
        check("blk_after_res", bus.alu_res_o, 32'd2);
        check("blk_after_valid", 32'(bus.valid_mem_o), 32'h1);

        // Load, then block+inject holds, then inject alone bubbles
        drive(ALU_ADD, 32'h8, 32'h8, 0, 0, 0, 0);
        bus.memop_rd_i   = 1'b1;
        bus.memop_type_i = MEMOP_WORD;
        step();
        check("ld_rd", 32'(bus.memop_rd_o), 32'h1);
        check("ld_res", bus.alu_res_o, 32'h10);
        check("ld_type", 32'(bus.memop_type_o), 32'h2);
        drive(ALU_ADD, 32'h30, 32'h0, 0, 0, 0, 0);
        bus.memop_rd_i    = 1'b1;
        bus.block_ex_i    = 1'b1;
        bus.inject_nops_i = 1'b1;
        step();
        check("bi_rd", 32'(bus.memop_rd_o), 32'h1);
        check("bi_valid", 32'(bus.valid_mem_o), 32'h1);
        check("bi_res", bus.alu_res_o, 32'h10);
        bus.block_ex_i = 1'b0;
        step();
        check("inj_rd", 32'(bus.memop_rd_o), 32'h0);
        check("inj_valid", 32'(bus.valid_mem_o), 32'h0);
        bus.inject_nops_i = 1'b0;

        // Asynchronous reset while a squash is pending
        drive(ALU_BEQ, 32'h100, 32'h20, 5, 5, 0, 0);
        step();
        check("rst_pre_tkn", 32'(bus.tkn_br_o), 32'h1);
        #1 rsn_i = 1'b0;
        #1;
        check_zero("async_rst");
        #3 rsn_i = 1'b1;
        drive(ALU_ADD, 2, 3, 0, 0, 0, 0);
        step();
        check("rst_after_res", bus.alu_res_o, 32'd5);
        check("rst_after_valid", 32'(bus.valid_mem_o), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
